// File: rtl/jtag_pkg.sv
// Shared constants for the JTAG TAP core: TAP state codes, instruction codes,
// IR capture pattern and the data-register selector type.
package jtag_pkg;

   // TAP state codes, IEEE 1149.1 hex encoding
   localparam logic [3:0] ST_TLR    = 4'hF;
   localparam logic [3:0] ST_RTI    = 4'hC;
   localparam logic [3:0] ST_SEL_DR = 4'h7;
   localparam logic [3:0] ST_CAP_DR = 4'h6;
   localparam logic [3:0] ST_SH_DR  = 4'h2;
   localparam logic [3:0] ST_EX1_DR = 4'h1;
   localparam logic [3:0] ST_PAU_DR = 4'h3;
   localparam logic [3:0] ST_EX2_DR = 4'h0;
   localparam logic [3:0] ST_UPD_DR = 4'h5;
   localparam logic [3:0] ST_SEL_IR = 4'h4;
   localparam logic [3:0] ST_CAP_IR = 4'hE;
   localparam logic [3:0] ST_SH_IR  = 4'hA;
   localparam logic [3:0] ST_EX1_IR = 4'h9;
   localparam logic [3:0] ST_PAU_IR = 4'hB;
   localparam logic [3:0] ST_EX2_IR = 4'h8;
   localparam logic [3:0] ST_UPD_IR = 4'hD;

   // Instruction codes; wider IRs zero-extend these, BYPASS is all ones
   localparam logic [3:0] INS_EXTEST = 4'b0000;
   localparam logic [3:0] INS_IDCODE = 4'b0001;
   localparam logic [3:0] INS_SAMPLE = 4'b0010;
   localparam logic [3:0] INS_INTEST = 4'b0011;
   localparam logic [3:0] INS_USER   = 4'b1000;

   // Loaded into the IR shift register at Capture-IR (LSBs 01, rest zero)
   localparam logic [1:0] IR_CAPTURE = 2'b01;

   typedef enum logic [1:0] {
      DR_BYPASS = 2'd0,
      DR_IDCODE = 2'd1,
      DR_BSR    = 2'd2,
      DR_USER   = 2'd3
   } dr_sel_e;

endpackage

// File: rtl/tap_fsm.sv
// TAP controller: 16-state IEEE 1149.1 state machine with decoded action strobes.
//
// state  | meaning
// TLR    | test-logic-reset, IR forced to IDCODE
// RTI    | run-test/idle
// SEL_DR | select DR scan
// CAP_DR | capture selected DR
// SH_DR  | shift selected DR
// EX1_DR | exit1 DR
// PAU_DR | pause DR, shift register held
// EX2_DR | exit2 DR
// UPD_DR | update selected DR latch
// SEL_IR | select IR scan
// CAP_IR | capture IR pattern
// SH_IR  | shift IR
// EX1_IR | exit1 IR
// PAU_IR | pause IR
// EX2_IR | exit2 IR
// UPD_IR | update instruction
module tap_fsm
   import jtag_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tms,
   output logic [3:0] state,
   output logic       in_tlr,
   output logic       capture_ir,
   output logic       shift_ir,
   output logic       update_ir,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr
);

   logic [3:0] state_nxt;

   // Standard TMS-driven transitions
   always_comb begin
      state_nxt = ST_TLR;
      case (state)
         ST_TLR:    state_nxt = tms ? ST_TLR    : ST_RTI;
         ST_RTI:    state_nxt = tms ? ST_SEL_DR : ST_RTI;
         ST_SEL_DR: state_nxt = tms ? ST_SEL_IR : ST_CAP_DR;
         ST_CAP_DR: state_nxt = tms ? ST_EX1_DR : ST_SH_DR;
         ST_SH_DR:  state_nxt = tms ? ST_EX1_DR : ST_SH_DR;
         ST_EX1_DR: state_nxt = tms ? ST_UPD_DR : ST_PAU_DR;
         ST_PAU_DR: state_nxt = tms ? ST_EX2_DR : ST_PAU_DR;
         ST_EX2_DR: state_nxt = tms ? ST_UPD_DR : ST_SH_DR;
         ST_UPD_DR: state_nxt = tms ? ST_SEL_DR : ST_RTI;
         ST_SEL_IR: state_nxt = tms ? ST_TLR    : ST_CAP_IR;
         ST_CAP_IR: state_nxt = tms ? ST_EX1_IR : ST_SH_IR;
         ST_SH_IR:  state_nxt = tms ? ST_EX1_IR : ST_SH_IR;
         ST_EX1_IR: state_nxt = tms ? ST_UPD_IR : ST_PAU_IR;
         ST_PAU_IR: state_nxt = tms ? ST_EX2_IR : ST_PAU_IR;
         ST_EX2_IR: state_nxt = tms ? ST_UPD_IR : ST_SH_IR;
         ST_UPD_IR: state_nxt = tms ? ST_SEL_DR : ST_RTI;
         default:   state_nxt = ST_TLR;
      endcase
   end

   // State register with synchronous reset into TLR
   always_ff @(posedge clk) begin
      if (rst) state <= ST_TLR;
      else     state <= state_nxt;
   end

   // Actions fire on the edge taken while in the named state
   always_comb begin
      in_tlr     = (state == ST_TLR);
      capture_ir = (state == ST_CAP_IR);
      shift_ir   = (state == ST_SH_IR);
      update_ir  = (state == ST_UPD_IR);
      capture_dr = (state == ST_CAP_DR);
      shift_dr   = (state == ST_SH_DR);
      update_dr  = (state == ST_UPD_DR);
   end

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG test-access core: TAP FSM, IR, bypass, IDCODE, boundary scan and user DR.
module jtag_tap_core
   import jtag_pkg::*;
#(
   parameter int          IR_W       = 4,
   parameter int          N_CH       = 2,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
   parameter int          USER_W     = 16
) (
   input  logic              TCK,
   input  logic              TRST,
   input  logic              TMS,
   input  logic              TDI,
   output logic              TDO,
   output logic              TDO_EN,
   input  logic [N_CH-1:0]   PIN_IN,
   input  logic [N_CH-1:0]   CORE_IN,
   output logic [N_CH-1:0]   CORE_OUT,
   output logic [N_CH-1:0]   PIN_OUT,
   input  logic [USER_W-1:0] USER_CAPTURE,
   output logic [USER_W-1:0] USER_DATA,
   output logic              USER_UPDATE,
   output logic [3:0]        STATE,
   output logic [IR_W-1:0]   IR_OUT
);

   localparam int BSR_W = 2 * N_CH;

   logic in_tlr, capture_ir, shift_ir, update_ir;
   logic capture_dr, shift_dr, update_dr;

   logic [IR_W-1:0]   ir_q, ir_sr;
   logic              bypass_sr;
   logic [31:0]       id_sr;
   logic [BSR_W-1:0]  bsr_sr, bsr_lat;
   logic [USER_W-1:0] user_sr, user_data;
   logic              user_update;
   logic              tdo_q, tdo_en_q, rst_mask;
   logic              dr_lsb;
   logic              is_extest, is_intest;
   dr_sel_e           dr_sel;

   tap_fsm u_fsm (
      .clk        (TCK),
      .rst        (TRST),
      .tms        (TMS),
      .state      (STATE),
      .in_tlr     (in_tlr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr)
   );

   // Instruction register: shift path plus the active instruction
   always_ff @(posedge TCK) begin
      if (TRST) begin
         ir_q  <= IR_W'(INS_IDCODE);
         ir_sr <= '0;
      end else begin
         if (capture_ir)    ir_sr <= IR_W'(IR_CAPTURE);
         else if (shift_ir) ir_sr <= {TDI, ir_sr[IR_W-1:1]};
         if (in_tlr)         ir_q <= IR_W'(INS_IDCODE);
         else if (update_ir) ir_q <= ir_sr;
      end
   end

   // Instruction decode; unknown codes fall back to bypass
   always_comb begin
      is_extest = (ir_q == IR_W'(INS_EXTEST));
      is_intest = (ir_q == IR_W'(INS_INTEST));
      dr_sel    = DR_BYPASS;
      if (is_extest || is_intest || (ir_q == IR_W'(INS_SAMPLE))) dr_sel = DR_BSR;
      else if (ir_q == IR_W'(INS_IDCODE))                        dr_sel = DR_IDCODE;
      else if (ir_q == IR_W'(INS_USER))                          dr_sel = DR_USER;
   end

   // Data registers: capture, shift and update of whichever DR is selected
   always_ff @(posedge TCK) begin
      if (TRST) begin
         bypass_sr   <= 1'b0;
         id_sr       <= '0;
         bsr_sr      <= '0;
         bsr_lat     <= '0;
         user_sr     <= '0;
         user_data   <= '0;
         user_update <= 1'b0;
      end else begin
         user_update <= 1'b0;
         if (capture_dr) begin
            case (dr_sel)
               DR_IDCODE: id_sr     <= IDCODE_VAL;
               DR_BSR:    bsr_sr    <= {CORE_IN, PIN_IN};
               DR_USER:   user_sr   <= USER_CAPTURE;
               default:   bypass_sr <= 1'b0;
            endcase
         end
         if (shift_dr) begin
            case (dr_sel)
               DR_IDCODE: id_sr     <= {TDI, id_sr[31:1]};
               DR_BSR:    bsr_sr    <= {TDI, bsr_sr[BSR_W-1:1]};
               DR_USER:   user_sr   <= (user_sr >> 1) | (USER_W'(TDI) << (USER_W - 1));
               default:   bypass_sr <= TDI;
            endcase
         end
         if (update_dr) begin
            if (dr_sel == DR_BSR) bsr_lat <= bsr_sr;
            if (dr_sel == DR_USER) begin
               user_data   <= user_sr;
               user_update <= 1'b1;
            end
         end
      end
   end

   // Serial output source for the selected DR
   always_comb begin
      case (dr_sel)
         DR_IDCODE: dr_lsb = id_sr[0];
         DR_BSR:    dr_lsb = bsr_sr[0];
         DR_USER:   dr_lsb = user_sr[0];
         default:   dr_lsb = bypass_sr;
      endcase
   end

   // TDO launches on the falling edge so it is stable at the next rising edge
   always_ff @(negedge TCK) begin
      tdo_q    <= shift_ir ? ir_sr[0] : (shift_dr ? dr_lsb : 1'b0);
      tdo_en_q <= shift_ir | shift_dr;
   end

   // Holds TDO quiet for the half cycle between a reset edge and the next falling edge
   always_ff @(posedge TCK) begin
      rst_mask <= TRST;
   end

   // Pin/core muxing is combinational from the active instruction and latches
   always_comb begin
      CORE_OUT = PIN_IN;
      PIN_OUT  = CORE_IN;
      if (is_extest) PIN_OUT  = bsr_lat[BSR_W-1:N_CH];
      if (is_intest) CORE_OUT = bsr_lat[N_CH-1:0];
   end

   assign TDO         = tdo_q & ~rst_mask;
   assign TDO_EN      = tdo_en_q & ~rst_mask;
   assign USER_DATA   = user_data;
   assign USER_UPDATE = user_update;
   assign IR_OUT      = ir_q;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: directed TAP sequences, a per-cycle reference model
// and literal expectations for each scenario.
module tb_jtag_tap_core;

   logic        TCK = 1'b0;
   logic        TRST, TMS, TDI;
   logic        TDO, TDO_EN;
   logic [1:0]  PIN_IN, CORE_IN, CORE_OUT, PIN_OUT;
   logic [15:0] USER_CAPTURE, USER_DATA;
   logic        USER_UPDATE;
   logic [3:0]  STATE;
   logic [3:0]  IR_OUT;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   jtag_tap_core #(
      .IR_W(4), .N_CH(2), .IDCODE_VAL(32'h1000_0001), .USER_W(16)
   ) dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
      .PIN_IN(PIN_IN), .CORE_IN(CORE_IN), .CORE_OUT(CORE_OUT), .PIN_OUT(PIN_OUT),
      .USER_CAPTURE(USER_CAPTURE), .USER_DATA(USER_DATA), .USER_UPDATE(USER_UPDATE),
      .STATE(STATE), .IR_OUT(IR_OUT)
   );

   always #5 TCK = ~TCK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [3:0]  nx0 [16];
   logic [3:0]  nx1 [16];
   logic [3:0]  m_state = 4'hF;
   logic [3:0]  m_ir = 4'h1;
   logic [3:0]  m_ir_sr = 4'h0;
   logic [63:0] m_dr = 64'h0;
   logic [3:0]  m_bsr_lat = 4'h0;
   logic [15:0] m_user = 16'h0;
   logic        m_upd = 1'b0;

   initial begin
      // IEEE 1149.1 transition table: {current, next on TMS=0, next on TMS=1}
      nx0[4'hF] = 4'hC; nx1[4'hF] = 4'hF;
      nx0[4'hC] = 4'hC; nx1[4'hC] = 4'h7;
      nx0[4'h7] = 4'h6; nx1[4'h7] = 4'h4;
      nx0[4'h6] = 4'h2; nx1[4'h6] = 4'h1;
      nx0[4'h2] = 4'h2; nx1[4'h2] = 4'h1;
      nx0[4'h1] = 4'h3; nx1[4'h1] = 4'h5;
      nx0[4'h3] = 4'h3; nx1[4'h3] = 4'h0;
      nx0[4'h0] = 4'h2; nx1[4'h0] = 4'h5;
      nx0[4'h5] = 4'hC; nx1[4'h5] = 4'h7;
      nx0[4'h4] = 4'hE; nx1[4'h4] = 4'hF;
      nx0[4'hE] = 4'hA; nx1[4'hE] = 4'h9;
      nx0[4'hA] = 4'hA; nx1[4'hA] = 4'h9;
      nx0[4'h9] = 4'hB; nx1[4'h9] = 4'hD;
      nx0[4'hB] = 4'hB; nx1[4'hB] = 4'h8;
      nx0[4'h8] = 4'hA; nx1[4'h8] = 4'hD;
      nx0[4'hD] = 4'hC; nx1[4'hD] = 4'h7;
   end

   function automatic int dr_len(input logic [3:0] ir);
      if (ir == 4'd0 || ir == 4'd2 || ir == 4'd3) return 4;
      if (ir == 4'd1) return 32;
      if (ir == 4'd8) return 16;
      return 1;
   endfunction

   always @(posedge TCK) begin
      int len;
      len = dr_len(m_ir);
      if (TRST) begin
         m_state = 4'hF; m_ir = 4'h1; m_ir_sr = 4'h0; m_dr = 64'h0;
         m_bsr_lat = 4'h0; m_user = 16'h0; m_upd = 1'b0;
      end else begin
         m_upd = 1'b0;
         case (m_state)
            4'hF: m_ir = 4'h1;
            4'hE: m_ir_sr = 4'b0001;
            4'hA: m_ir_sr = {TDI, m_ir_sr[3:1]};
            4'hD: m_ir = m_ir_sr;
            4'h6: begin
               if (len == 4)       m_dr = 64'({CORE_IN, PIN_IN});
               else if (len == 32) m_dr = 64'h1000_0001;
               else if (len == 16) m_dr = 64'(USER_CAPTURE);
               else                m_dr = 64'h0;
            end
            4'h2: m_dr = (m_dr >> 1) | (64'(TDI) << (len - 1));
            4'h5: begin
               if (len == 4) m_bsr_lat = m_dr[3:0];
               if (len == 16) begin m_user = m_dr[15:0]; m_upd = 1'b1; end
            end
            default: ;
         endcase
         m_state = TMS ? nx1[m_state] : nx0[m_state];
      end
   end

   // Per-cycle comparison against the model, away from both clock edges
   always @(negedge TCK) begin
      logic       e_en, e_tdo;
      logic [1:0] e_pin, e_core;
      #1;
      if (check_en) begin
         e_en  = (m_state == 4'hA) || (m_state == 4'h2);
         e_tdo = (m_state == 4'hA) ? m_ir_sr[0] : ((m_state == 4'h2) ? m_dr[0] : 1'b0);
         e_pin  = CORE_IN;
         e_core = PIN_IN;
         if (m_ir == 4'd0) e_pin  = m_bsr_lat[3:2];
         if (m_ir == 4'd3) e_core = m_bsr_lat[1:0];
         chk("m_state", STATE, m_state);
         chk("m_ir", IR_OUT, m_ir);
         chk("m_tdo_en", TDO_EN, e_en);
         chk("m_tdo", TDO, e_tdo);
         chk("m_pin_out", PIN_OUT, e_pin);
         chk("m_core_out", CORE_OUT, e_core);
         chk("m_user_data", USER_DATA, m_user);
         chk("m_user_update", USER_UPDATE, m_upd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input logic tms, input logic tdi);
      TMS = tms; TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #2;
   endtask

   // From RTI: scan n IR bits, update, return to RTI
   task automatic shift_ir(input int n, input logic [63:0] din, output logic [63:0] dout);
      dout = '0;
      tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < n; i++) begin
         dout[i] = TDO;
         tick(i == n - 1, din[i]);
      end
      tick(1, 0); tick(0, 0);
   endtask

   // From RTI: scan n DR bits and stop in Update-DR (caller takes the update edge)
   task automatic shift_dr(input int n, input logic [63:0] din,
                           output logic [63:0] dout, output logic en_all);
      dout = '0; en_all = 1'b1;
      tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < n; i++) begin
         dout[i] = TDO;
         en_all  = en_all & TDO_EN;
         tick(i == n - 1, din[i]);
      end
      tick(1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] dout;
      logic        en;
      TRST = 1'b1; TMS = 1'b0; TDI = 1'b0;
      PIN_IN = 2'b00; CORE_IN = 2'b10; USER_CAPTURE = 16'h0;
      tick(0, 0);
      chk("rst_state", STATE, 4'hF);
      chk("rst_ir", IR_OUT, 4'h1);
      chk("rst_tdo_en", TDO_EN, 1'b0);
      chk("rst_pin_out", PIN_OUT, 2'b10);
      TRST = 1'b0; check_en = 1'b1;

      // IDCODE read-out
      tick(0, 0);
      shift_dr(32, 64'h0, dout, en);
      chk("idcode", dout[31:0], 32'h1000_0001);
      chk("idcode_en", en, 1'b1);
      tick(0, 0);

      // BYPASS: one-bit delay, captured 0 first
      shift_ir(4, 64'hF, dout);
      chk("capture_ir", dout[3:0], 4'b0001);
      chk("ir_bypass", IR_OUT, 4'hF);
      shift_dr(5, 64'b01010, dout, en);
      chk("bypass", dout[4:0], 5'b10100);
      tick(0, 0);

      // SAMPLE capture, preload, then EXTEST drives the preloaded outputs
      PIN_IN = 2'b10; CORE_IN = 2'b01;
      shift_ir(4, 64'h2, dout);
      shift_dr(4, 64'b1100, dout, en);
      chk("sample_capture", dout[3:0], 4'b0110);
      tick(0, 0);
      chk("sample_transparent", PIN_OUT, 2'b01);
      shift_ir(4, 64'h0, dout);
      chk("extest_pin_out", PIN_OUT, 2'b11);
      chk("extest_core_out", CORE_OUT, 2'b10);

      // USER register round trip
      USER_CAPTURE = 16'hA5A5;
      shift_ir(4, 64'h8, dout);
      shift_dr(16, 64'h1234, dout, en);
      chk("user_capture", dout[15:0], 16'hA5A5);
      tick(0, 0);
      chk("user_data", USER_DATA, 16'h1234);
      chk("user_update_hi", USER_UPDATE, 1'b1);
      tick(0, 0);
      chk("user_update_lo", USER_UPDATE, 1'b0);

      // Pause-DR holds the shift register
      tick(1, 0); tick(0, 0); tick(0, 0);
      chk("pause_b0", TDO, 1'b1);
      tick(0, 0);
      chk("pause_b1", TDO, 1'b0);
      tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 0); tick(1, 0); tick(0, 0);
      chk("pause_hold_b2", TDO, 1'b1);
      tick(0, 0);
      chk("pause_b3", TDO, 1'b0);
      tick(1, 0); tick(1, 0); tick(0, 0);

      // Capture straight to Exit1/Update with zero shifts
      USER_CAPTURE = 16'h0F0F;
      tick(1, 0); tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0);
      chk("zero_shift_data", USER_DATA, 16'h0F0F);
      chk("zero_shift_strobe", USER_UPDATE, 1'b1);

      // INTEST drives the core from the input-cell latches
      PIN_IN = 2'b10; CORE_IN = 2'b01;
      shift_ir(4, 64'h3, dout);
      shift_dr(4, 64'b0001, dout, en);
      tick(0, 0);
      chk("intest_core_out", CORE_OUT, 2'b01);
      chk("intest_pin_out", PIN_OUT, 2'b01);

      // EXTEST, then TRST in the middle of a DR shift
      shift_ir(4, 64'h0, dout);
      shift_dr(4, 64'b1100, dout, en);
      tick(0, 0);
      chk("extest2_pin_out", PIN_OUT, 2'b11);
      tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1); tick(0, 1);
      TRST = 1'b1;
      tick(0, 0);
      TRST = 1'b0;
      chk("trst_state", STATE, 4'hF);
      chk("trst_ir", IR_OUT, 4'h1);
      chk("trst_pin_out", PIN_OUT, 2'b01);
      chk("trst_tdo_en", TDO_EN, 1'b0);
      chk("trst_user", USER_DATA, 16'h0);
      tick(0, 0);
      shift_ir(4, 64'h0, dout);
      chk("trst_latch_clear", PIN_OUT, 2'b00);

      // Five TMS=1 edges from Pause-IR reach TLR
      tick(1, 0); tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
      chk("pause_ir", STATE, 4'hB);
      for (int i = 0; i < 5; i++) tick(1, 0);
      chk("tms5_tlr", STATE, 4'hF);
      tick(1, 0);
      chk("tlr_ir", IR_OUT, 4'h1);

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
